// File: rtl/rect_deser_if.sv
// Bundle between the 2-lane serial rectangular stream and the parallel word output.
// The master side is the source and consumer, and the slave side is the deserializer.
interface rect_deser_if #(
  parameter int W = 8
);
  logic [1:0]   bit_in;
  logic         bit_valid;
  logic         sof;
  logic         out_ready;
  logic [W-1:0] X_out;
  logic [W-1:0] Y_out;
  logic         out_valid;
  logic         frame_err;
  logic         overrun;
  logic [7:0]   frame_cnt;

  modport master (
    output bit_in, bit_valid, sof, out_ready,
    input  X_out, Y_out, out_valid, frame_err, overrun, frame_cnt
  );

  modport slave (
    input  bit_in, bit_valid, sof, out_ready,
    output X_out, Y_out, out_valid, frame_err, overrun, frame_cnt
  );
endinterface

// File: rtl/rect_deser.sv
// Reassembles 2-lane MSB-first serial X/Y frames into parallel words behind a valid/ready register.
// It also flags aborted frames, latches overruns and counts delivered words.
module rect_deser #(
  parameter int W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  rect_deser_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_reg;
  logic [W-1:0]    sx_reg, sy_reg, x_reg, y_reg;
  logic [CW-1:0]   cnt_reg;
  logic            out_valid_reg, frame_err_reg, overrun_reg;
  logic [7:0]      frame_cnt_reg;

  logic            start, take, abort, done, xfer, free;
  logic [W:0]      x_shift, y_shift;
  logic [W-1:0]    sx_next, sy_next;
  logic [CW-1:0]   cnt_next;

  always_comb begin
    start   = bus.bit_valid && bus.sof;
    take    = bus.bit_valid && (start || state_reg == SHIFT);
    abort   = start && state_reg == SHIFT;
    x_shift = {sx_reg, bus.bit_in[1]};
    y_shift = {sy_reg, bus.bit_in[0]};
    if (start) begin
      // sof always opens a fresh frame, so an abort can never coincide with completion
      sx_next  = W'(bus.bit_in[1]);
      sy_next  = W'(bus.bit_in[0]);
      cnt_next = CW'(1);
    end else begin
      sx_next  = x_shift[W-1:0];
      sy_next  = y_shift[W-1:0];
      cnt_next = cnt_reg + 1'b1;
    end
    done = take && (cnt_next == CW'(W));
    xfer = out_valid_reg && bus.out_ready;
    free = !out_valid_reg || bus.out_ready;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sx_reg        <= '0;
      sy_reg        <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else begin
      frame_err_reg <= abort;
      if (xfer)
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      if (take) begin
        sx_reg <= sx_next;
        sy_reg <= sy_next;
        if (done) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= SHIFT;
          cnt_reg   <= cnt_next;
        end
      end
      // A word delivered on this edge frees the register for a word completing on it
      if (done && free) begin
        x_reg         <= sx_next;
        y_reg         <= sy_next;
        out_valid_reg <= 1'b1;
      end else begin
        if (done)
          overrun_reg <= 1'b1;
        if (xfer)
          out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.X_out     = x_reg;
  assign bus.Y_out     = y_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_rect_deser.sv
// Directed bench for rect_deser: drives frames on the falling edge and checks outputs there too.
module tb_rect_deser;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad = 0;

  rect_deser_if #(.W(8)) bus ();

  rect_deser #(.W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] b);
    @(negedge CLK);
    bus.bit_valid = v;
    bus.sof       = s;
    bus.bit_in    = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00);
  endtask

  // Sends one 8-bit frame; gap > 0 inserts that many idle cycles after the 4th bit.
  task automatic frame(input logic [7:0] x, input logic [7:0] y, input logic err_exp,
                       input logic rdy_last, input int gap);
    for (int i = 7; i >= 0; i--) begin
      @(negedge CLK);
      if (i == 6) check("frame_err", {31'd0, bus.frame_err}, {31'd0, err_exp});
      if (i == 0) bus.out_ready = rdy_last;
      bus.bit_valid = 1'b1;
      bus.sof       = (i == 7);
      bus.bit_in    = {x[i], y[i]};
      if (i == 4 && gap > 0) begin
        for (int g = 0; g < gap; g++) begin
          idle();
          check("gap_nvalid", {31'd0, bus.out_valid}, 32'd0);
        end
      end
    end
  endtask

  task automatic check_word(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic v, input logic [7:0] cnt);
    check({tag, "_x"}, {24'd0, bus.X_out}, {24'd0, x});
    check({tag, "_y"}, {24'd0, bus.Y_out}, {24'd0, y});
    check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, "_cnt"}, {24'd0, bus.frame_cnt}, {24'd0, cnt});
  endtask

  initial begin
    bus.bit_in    = 2'b00;
    bus.bit_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.out_ready = 1'b1;
    RST = 1'b1;
    idle();
    idle();
    RST = 1'b0;
    check_word("reset", 8'h00, 8'h00, 1'b0, 8'd0);
    check("reset_ovr", {31'd0, bus.overrun}, 32'd0);
    check("reset_err", {31'd0, bus.frame_err}, 32'd0);

    // basic frame
    frame(8'h03, 8'h02, 1'b0, 1'b1, 0);
    idle();
    check_word("basic", 8'h03, 8'h02, 1'b1, 8'd0);
    idle();
    check_word("basic_done", 8'h03, 8'h02, 1'b0, 8'd1);

    // negative values with a mid-frame gap
    frame(8'hFD, 8'hFE, 1'b0, 1'b1, 3);
    idle();
    check_word("neg", 8'hFD, 8'hFE, 1'b1, 8'd1);
    idle();
    check_word("neg_done", 8'hFD, 8'hFE, 1'b0, 8'd2);

    // abort after 4 bits, then a full frame
    drive(1'b1, 1'b1, 2'b11);
    drive(1'b1, 1'b0, 2'b01);
    drive(1'b1, 1'b0, 2'b10);
    drive(1'b1, 1'b0, 2'b11);
    frame(8'h01, 8'h7F, 1'b1, 1'b1, 0);
    idle();
    check_word("abort", 8'h01, 8'h7F, 1'b1, 8'd2);
    check("abort_err_clr", {31'd0, bus.frame_err}, 32'd0);
    idle();
    check_word("abort_done", 8'h01, 8'h7F, 1'b0, 8'd3);

    // backpressure: B is dropped, A retained
    bus.out_ready = 1'b0;
    frame(8'h11, 8'h22, 1'b0, 1'b0, 0);
    frame(8'h33, 8'h44, 1'b0, 1'b0, 0);
    idle();
    check_word("bp", 8'h11, 8'h22, 1'b1, 8'd3);
    check("bp_ovr", {31'd0, bus.overrun}, 32'd1);
    bus.out_ready = 1'b1;
    idle();
    check_word("bp_done", 8'h11, 8'h22, 1'b0, 8'd4);
    check("bp_ovr_sticky", {31'd0, bus.overrun}, 32'd1);

    // same-edge replace: A delivered while B loads
    bus.out_ready = 1'b0;
    frame(8'h55, 8'h66, 1'b0, 1'b0, 0);
    idle();
    check_word("rep_a", 8'h55, 8'h66, 1'b1, 8'd4);
    frame(8'h77, 8'h88, 1'b0, 1'b1, 0);
    idle();
    check_word("rep_b", 8'h77, 8'h88, 1'b1, 8'd5);
    idle();
    check_word("rep_done", 8'h77, 8'h88, 1'b0, 8'd6);

    // reset mid-frame with overrun set
    drive(1'b1, 1'b1, 2'b10);
    drive(1'b1, 1'b0, 2'b01);
    drive(1'b1, 1'b0, 2'b11);
    RST = 1'b1;
    drive(1'b1, 1'b0, 2'b01);
    RST = 1'b0;
    check_word("rst_mid", 8'h00, 8'h00, 1'b0, 8'd0);
    check("rst_mid_ovr", {31'd0, bus.overrun}, 32'd0);
    drive(1'b1, 1'b0, 2'b11);
    drive(1'b1, 1'b0, 2'b10);
    frame(8'h9A, 8'hBC, 1'b0, 1'b1, 0);
    idle();
    check_word("post_rst", 8'h9A, 8'hBC, 1'b1, 8'd0);
    idle();
    check_word("post_rst_done", 8'h9A, 8'hBC, 1'b0, 8'd1);
    check("post_rst_ovr", {31'd0, bus.overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rect_deser.md
# rect_deser

Downstream stage of the polar-to-rectangular state machine. It takes the 2-lane serial rectangular stream that the converter emits one bit per lane per cycle. It reassembles each frame into parallel two's-complement X and Y words and presents them on a valid/ready output register. It flags malformed frames and output overruns, and counts delivered frames.

## Interface
Parameters:
- W, 8: bits per lane per frame; also the width of X_out and Y_out.

Ports:
- CLK, input, 1: single clock; all logic is rising-edge.
- RST, input, 1: synchronous, active-high reset.
- bit_in, input, 2: serial data. bit_in[1] is the X lane and bit_in[0] is the Y lane. Both lanes are MSB first.
- bit_valid, input, 1: bit_in is valid this cycle.
- sof, input, 1: start of frame. Meaningful only when bit_valid=1, and marks the MSB.
- out_ready, input, 1: the consumer accepts the output word.
- X_out, output, W: assembled X word, two's complement.
- Y_out, output, W: assembled Y word, two's complement.
- out_valid, output, 1: X_out and Y_out hold an undelivered word.
- frame_err, output, 1: one-cycle pulse on an aborted (short) frame.
- overrun, output, 1: sticky flag. Set when a completed frame is dropped; cleared only by RST.
- frame_cnt, output, 8: number of words delivered, i.e. handshakes completed; wraps 255→0.

## Operation
- There are two internal shift registers, sx and sy, each W bits. There is a bit counter cnt with range 0..W.
- The FSM has two states:
  - IDLE: cnt=0. Accepted bits are discarded unless sof=1.
  - SHIFT: a frame is in progress.
- IDLE with bit_valid=1 and sof=1:
  - sx←bit_in[1], sy←bit_in[0], cnt←1, go to SHIFT.
  - If W=1 the frame completes immediately.
- IDLE with bit_valid=1 and sof=0: the bit is ignored and no flag is raised.
- SHIFT with bit_valid=1 and sof=0: shift left, new bit into the LSB, cnt←cnt+1.
- SHIFT with bit_valid=0: hold. Gaps are permitted and there is no timeout.
- SHIFT with bit_valid=1 and sof=1 (abort): the partial frame is discarded and frame_err pulses for one cycle. The new bit becomes the MSB of a new frame (cnt←1), and the state stays SHIFT.
- Frame completion occurs when the Wth bit is accepted:
  - The completed word is {sx,sy} with that bit shifted in. cnt returns to 0 and the state returns to IDLE.
  - If the output register is free, the word loads: X_out←word, Y_out←word, out_valid←1.
  - The output register counts as free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge.
  - Otherwise the new word is dropped, overrun←1, and X_out/Y_out are unchanged.
- Output handshake:
  - A transfer occurs on a rising edge where out_valid=1 and out_ready=1. frame_cnt increments on each transfer.
  - If no new word loads on that edge, out_valid←0.
  - X_out and Y_out are stable while out_valid=1 and not yet transferred.
- Reset, checked at the rising edge with RST=1:
  - State←IDLE, cnt←0, sx/sy←0.
  - X_out←0, Y_out←0, out_valid←0, frame_err←0, overrun←0, frame_cnt←0.
  - A partial frame in progress at reset is discarded silently.
  - RST has priority over every other input.

## Timing
- Everything is registered; there are no combinational input→output paths.
- Latency: if the Wth bit is sampled at edge k, out_valid=1 and the word are visible after edge k.
- Minimum frame time is W cycles. Throughput is 1 word per W cycles with out_ready held high, with no bubbles.
- frame_err is high for exactly the cycle after the aborting edge.
- Completion and transfer on the same edge: the new word replaces the old, out_valid stays 1, and frame_cnt increments by 1.
- Abort and completion cannot coincide, because sof forces cnt←1.
- frame_cnt wraps from 255 to 0 on the next transfer.

## Test plan
- Basic frame (W=8, out_ready=1):
  - Stimulus: sof on the first bit; 8 consecutive bit_valid cycles with {X,Y} lanes X=00000011, Y=00000010 MSB first.
  - Expected: X_out=8'h03 and Y_out=8'h02 after the 8th edge; out_valid high one cycle; frame_cnt=1.
- Negative values with gaps:
  - Stimulus: X=8'hFD, Y=8'hFE with bit_valid low for 3 random cycles mid-frame.
  - Expected: identical words delivered; out_valid rises only after the 8th valid bit.
- Abort:
  - Stimulus: sof, 4 bits, then sof plus a full 8-bit frame X=8'h01, Y=8'h7F.
  - Expected: one frame_err pulse; then X_out=8'h01, Y_out=8'h7F.
- Backpressure and overrun:
  - Stimulus: out_ready=0; two back-to-back frames A (X=8'h11, Y=8'h22) then B.
  - Expected: X_out=8'h11 and Y_out=8'h22 retained; overrun=1 stays set; after out_ready=1, frame_cnt=1.
- Same-edge replace:
  - Stimulus: word A pending; assert out_ready on the edge that completes frame B.
  - Expected: out_valid stays 1, output=B, frame_cnt increments by 1.
- Reset:
  - Stimulus: RST high for 1 cycle mid-frame, with overrun set and frame_cnt=5.
  - Expected: all outputs 0. A following clean frame delivers correctly, and bits before the next sof are ignored.
